// File: rtl/e203_exu_flush_arb_if.sv
// e203_exu_flush_arb_if: flush request sources and the IFU flush port.
// The arbiter uses the master modport; the commit logic and IFU side use slave.
interface e203_exu_flush_arb_if #(parameter int PC_SIZE = 32);
   logic excp_req, dbg_req, brch_req;
   logic excp_ack, dbg_ack, brch_ack;
   logic [PC_SIZE-1:0] excp_op1, excp_op2, dbg_op1, dbg_op2, brch_op1, brch_op2;
   logic pipe_flush_req, pipe_flush_ack;
   logic [PC_SIZE-1:0] pipe_flush_add_op1, pipe_flush_add_op2;
   modport master (
      input  excp_req, dbg_req, brch_req, excp_op1, excp_op2, dbg_op1, dbg_op2,
             brch_op1, brch_op2, pipe_flush_ack,
      output excp_ack, dbg_ack, brch_ack, pipe_flush_req, pipe_flush_add_op1,
             pipe_flush_add_op2
   );
   modport slave (
      output excp_req, dbg_req, brch_req, excp_op1, excp_op2, dbg_op1, dbg_op2,
             brch_op1, brch_op2, pipe_flush_ack,
      input  excp_ack, dbg_ack, brch_ack, pipe_flush_req, pipe_flush_add_op1,
             pipe_flush_add_op2
   );
endinterface

// File: rtl/e203_exu_flush_arb.sv
// e203_exu_flush_arb: fixed-priority (excp > dbg > brch) flush arbiter with registered IFU operands.
// Define E203_FLUSH_ARB_CNT_EN to add saturating per-source flush counters.
module e203_exu_flush_arb #(
   parameter int PC_SIZE = 32
`ifdef E203_FLUSH_ARB_CNT_EN
   , parameter int CNT_W = 16
`endif
) (
   input  logic clk,
   input  logic rst,
   e203_exu_flush_arb_if.master fl,
   output logic [2:0] flush_src,
   output logic flush_pulse,
   output logic arb_busy
`ifdef E203_FLUSH_ARB_CNT_EN
   , output logic [CNT_W-1:0] cnt_excp
   , output logic [CNT_W-1:0] cnt_dbg
   , output logic [CNT_W-1:0] cnt_brch
`endif
);
   typedef enum logic [1:0] {IDLE, ISSUE, BLANK} state_t;
   state_t state_q, state_d;
   logic [2:0] src_q, src_d, win;
   logic [PC_SIZE-1:0] op1_q, op1_d, op2_q, op2_d, win_op1, win_op2;
   logic fire;
   always_comb begin
      win = fl.excp_req ? 3'b001 : fl.dbg_req ? 3'b010 : fl.brch_req ? 3'b100 : 3'b000;
      win_op1 = win[0] ? fl.excp_op1 : win[1] ? fl.dbg_op1 : fl.brch_op1;
      win_op2 = win[0] ? fl.excp_op2 : win[1] ? fl.dbg_op2 : fl.brch_op2;
      fire = state_q == ISSUE && fl.pipe_flush_ack && !rst;
      state_d = state_q;
      src_d = src_q;
      op1_d = op1_q;
      op2_d = op2_q;
      // one-hot src with excp in bit 0: a numerically smaller winner is strictly higher priority
      if (fire) begin
         state_d = BLANK;
         src_d = '0;
      end else if (state_q == BLANK) begin
         state_d = IDLE;
      end else if (win != '0 && (state_q == IDLE || win < src_q)) begin
         state_d = ISSUE;
         src_d = win;
         op1_d = win_op1;
         op2_d = win_op2;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         src_q <= '0;
         op1_q <= '0;
         op2_q <= '0;
      end else begin
         state_q <= state_d;
         src_q <= src_d;
         op1_q <= op1_d;
         op2_q <= op2_d;
      end
   end
   assign fl.pipe_flush_req = state_q == ISSUE;
   assign fl.pipe_flush_add_op1 = op1_q;
   assign fl.pipe_flush_add_op2 = op2_q;
   assign {fl.brch_ack, fl.dbg_ack, fl.excp_ack} = fire ? src_q : 3'b000;
   assign flush_src = src_q;
   assign flush_pulse = fire;
   assign arb_busy = state_q != IDLE;
`ifdef E203_FLUSH_ARB_CNT_EN
   logic [2:0][CNT_W-1:0] cnt_q, cnt_d;
   always_comb begin
      cnt_d = cnt_q;
      for (int i = 0; i < 3; i++) cnt_d[i] = cnt_q[i] + CNT_W'(fire && src_q[i] && !(&cnt_q[i]));
   end
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign cnt_excp = cnt_q[0];
   assign cnt_dbg = cnt_q[1];
   assign cnt_brch = cnt_q[2];
`endif
endmodule

// File: tb/tb_e203_exu_flush_arb.sv
// tb_e203_exu_flush_arb: directed test-plan sequences then random requests, checked against a
// priority/handshake reference model of the flush arbiter.
module tb_e203_exu_flush_arb;
   logic clk = 0, rst = 1;
   logic [2:0] flush_src;
   logic flush_pulse, arb_busy;
   int checks = 0, errors = 0;
   always #5 clk = ~clk;
   e203_exu_flush_arb_if #(.PC_SIZE(32)) f();
`ifdef E203_FLUSH_ARB_CNT_EN
   logic [3:0] cnt_excp, cnt_dbg, cnt_brch;
   e203_exu_flush_arb #(.PC_SIZE(32), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .fl(f), .flush_src(flush_src), .flush_pulse(flush_pulse),
      .arb_busy(arb_busy), .cnt_excp(cnt_excp), .cnt_dbg(cnt_dbg), .cnt_brch(cnt_brch));
`else
   e203_exu_flush_arb #(.PC_SIZE(32)) dut (
      .clk(clk), .rst(rst), .fl(f), .flush_src(flush_src), .flush_pulse(flush_pulse),
      .arb_busy(arb_busy));
`endif
   logic [2:0] pend = '0;
   logic [31:0] sop1[3], sop2[3];
   int m_own = -1, m_cnt[3] = '{0, 0, 0};
   bit m_iss = 0, m_blk = 0;
   logic [31:0] m_op1 = '0, m_op2 = '0;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask
   // one clock cycle: raise new requests, drive, check against the model, then advance the model
   task automatic cyc(input logic [2:0] nr, input logic pa, input logic r);
      logic [2:0] ea;
      int top;
      pend = pend | nr;
      rst = r;
      f.pipe_flush_ack = pa;
      {f.brch_req, f.dbg_req, f.excp_req} = pend;
      f.excp_op1 = sop1[0]; f.excp_op2 = sop2[0];
      f.dbg_op1 = sop1[1]; f.dbg_op2 = sop2[1];
      f.brch_op1 = sop1[2]; f.brch_op2 = sop2[2];
      #4;
      ea = (m_iss && pa && !r) ? 3'(1 << m_own) : 3'b000;
      check("pipe_flush_req", 64'(f.pipe_flush_req), 64'(m_iss));
      check("add_op1", 64'(f.pipe_flush_add_op1), 64'(m_op1));
      check("add_op2", 64'(f.pipe_flush_add_op2), 64'(m_op2));
      check("flush_src", 64'(flush_src), m_own < 0 ? 64'd0 : 64'(1 << m_own));
      check("acks", 64'({f.brch_ack, f.dbg_ack, f.excp_ack}), 64'(ea));
      check("flush_pulse", 64'(flush_pulse), 64'(ea != 0));
      check("arb_busy", 64'(arb_busy), 64'(m_iss || m_blk));
`ifdef E203_FLUSH_ARB_CNT_EN
      check("cnt_excp", 64'(cnt_excp), 64'(m_cnt[0]));
      check("cnt_dbg", 64'(cnt_dbg), 64'(m_cnt[1]));
      check("cnt_brch", 64'(cnt_brch), 64'(m_cnt[2]));
`endif
      top = -1;
      for (int i = 2; i >= 0; i--) if (pend[i]) top = i;
      if (r) begin
         m_own = -1; m_iss = 0; m_blk = 0; m_op1 = '0; m_op2 = '0;
         m_cnt = '{0, 0, 0};
      end else if (ea != 0) begin
         if (m_cnt[m_own] < 15) m_cnt[m_own]++;
         pend[m_own] = 0;
         m_own = -1; m_iss = 0; m_blk = 1;
      end else if (m_blk) begin
         m_blk = 0;
      end else if (top >= 0 && (!m_iss || top < m_own)) begin
         m_own = top; m_iss = 1; m_op1 = sop1[top]; m_op2 = sop2[top];
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      {f.excp_req, f.dbg_req, f.brch_req, f.pipe_flush_ack} = '0;
      for (int i = 0; i < 3; i++) begin
         sop1[i] = $urandom;
         sop2[i] = $urandom;
      end
      {f.excp_op1, f.excp_op2, f.dbg_op1, f.dbg_op2, f.brch_op1, f.brch_op2} = '0;
      repeat (2) @(posedge clk);
      #1;
      sop1[2] = 32'h8000_0100;
      sop2[2] = 32'h10;
      cyc(3'b100, 1, 0);
      repeat (3) cyc(3'b000, 1, 0);
      cyc(3'b101, 0, 0);
      cyc(3'b000, 0, 0);
      cyc(3'b000, 0, 0);
      repeat (6) cyc(3'b000, 1, 0);
      cyc(3'b100, 0, 0);
      cyc(3'b000, 0, 0);
      cyc(3'b010, 0, 0);
      cyc(3'b000, 0, 0);
      repeat (6) cyc(3'b000, 1, 0);
      cyc(3'b100, 0, 0);
      cyc(3'b010, 1, 0);
      repeat (5) cyc(3'b000, 1, 0);
      cyc(3'b001, 0, 0);
      cyc(3'b000, 0, 0);
      cyc(3'b000, 0, 1);
      repeat (4) cyc(3'b000, 1, 0);
      repeat (20) begin
         cyc(3'b100, 1, 0);
         cyc(3'b000, 1, 0);
         cyc(3'b000, 1, 0);
      end
      for (int n = 0; n < 3000; n++) begin
         logic [2:0] nr;
         for (int i = 0; i < 3; i++) begin
            if (!pend[i]) begin
               sop1[i] = $urandom;
               sop2[i] = $urandom;
            end
            nr[i] = $urandom_range(0, 3) == 0;
         end
         cyc(nr, $urandom_range(0, 2) == 0, $urandom_range(0, 99) == 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
